// File: rtl/branch_pkg.sv
// Shared branch-op encodings, FSM state type and resolve decode used by the predictor.
// Pure definitions; no latency and no flow control.
package branch_pkg;

    typedef logic [3:0] branch_op_t;

    localparam branch_op_t BRANCH_OP_NEVER    = 4'b0000;
    localparam branch_op_t BRANCH_OP_ZERO     = 4'b0101;
    localparam branch_op_t BRANCH_OP_NON_ZERO = 4'b1010;
    localparam branch_op_t BRANCH_OP_ALWAYS   = 4'b1111;

    typedef enum logic {INIT, RUN} state_t;

    // Unknown encodings resolve not-taken so a bad op never produces X.
    function automatic logic resolve_taken(input branch_op_t op, input logic alu_non_zero);
        logic taken;
        case (op)
            BRANCH_OP_ZERO:     taken = ~alu_non_zero;
            BRANCH_OP_NON_ZERO: taken = alu_non_zero;
            BRANCH_OP_ALWAYS:   taken = 1'b1;
            default:            taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve signals of the branch predictor.
// master = fetch/execute pipeline, slave = predictor; no backpressure.
interface branch_predictor_if #(
    parameter int XLEN = 64
);
    logic            ready_out;
    logic            lookup_valid_in;
    logic [XLEN-1:0] lookup_pc_in;
    logic            predict_valid_out;
    logic            predict_taken_out;
    logic [XLEN-1:0] predict_target_out;
    logic            resolve_valid_in;
    logic [XLEN-1:0] resolve_pc_in;
    logic [3:0]      resolve_op_in;
    logic            alu_non_zero_in;
    logic            predicted_taken_in;
    logic [XLEN-1:0] resolve_target_in;
    logic            taken_out;
    logic            mispredicted_out;

    modport master (
        output lookup_valid_in, lookup_pc_in, resolve_valid_in, resolve_pc_in,
               resolve_op_in, alu_non_zero_in, predicted_taken_in, resolve_target_in,
        input  ready_out, predict_valid_out, predict_taken_out, predict_target_out,
               taken_out, mispredicted_out
    );

    modport slave (
        input  lookup_valid_in, lookup_pc_in, resolve_valid_in, resolve_pc_in,
               resolve_op_in, alu_non_zero_in, predicted_taken_in, resolve_target_in,
        output ready_out, predict_valid_out, predict_taken_out, predict_target_out,
               taken_out, mispredicted_out
    );
endinterface

// File: rtl/branch_sat_counter.sv
// Combinational saturating up/down step of one prediction counter.
// Zero latency; no flow control.
module branch_sat_counter #(
    parameter int COUNTER_BITS = 2
) (
    input  logic [COUNTER_BITS-1:0] cnt_cur,
    input  logic                    inc,
    output logic [COUNTER_BITS-1:0] cnt_nxt
);
    always_comb begin
        cnt_nxt = cnt_cur;
        if (inc && (cnt_cur != '1)) begin
            cnt_nxt = cnt_cur + 1'b1;
        end else if (!inc && (cnt_cur != '0)) begin
            cnt_nxt = cnt_cur - 1'b1;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// BHT lookup (1-cycle registered) plus execute-side resolve/train; optional BTB with BRANCH_BTB_EN.
// No backpressure: lookups are ignored and training dropped until the table finishes INIT.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int INDEX_BITS   = 6,
    parameter int COUNTER_BITS = 2,
    parameter int TAG_BITS     = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [COUNTER_BITS-1:0] CNT_WNT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
    localparam logic [INDEX_BITS-1:0]   LAST_IDX = INDEX_BITS'(ENTRIES - 1);

    state_t                  state;
    logic [INDEX_BITS-1:0]   init_idx;
    logic [COUNTER_BITS-1:0] bht [ENTRIES];

    logic [INDEX_BITS-1:0]   lk_idx, up_idx;
    logic                    taken, train;
    logic [COUNTER_BITS-1:0] cnt_nxt, lk_cnt;
    logic                    pred_taken_nxt;
    logic [XLEN-1:0]         pred_tgt_nxt;

    assign lk_idx = bp.lookup_pc_in[INDEX_BITS+1:2];
    assign up_idx = bp.resolve_pc_in[INDEX_BITS+1:2];

    assign taken               = resolve_taken(bp.resolve_op_in, bp.alu_non_zero_in);
    assign bp.taken_out        = taken;
    assign bp.mispredicted_out = bp.resolve_valid_in & (taken ^ bp.predicted_taken_in);

    assign train = bp.resolve_valid_in && (state == RUN) &&
                   ((bp.resolve_op_in == BRANCH_OP_ZERO) || (bp.resolve_op_in == BRANCH_OP_NON_ZERO));

    branch_sat_counter #(.COUNTER_BITS(COUNTER_BITS)) u_sat (
        .cnt_cur (bht[up_idx]),
        .inc     (taken),
        .cnt_nxt (cnt_nxt)
    );

    // Same-index write this cycle wins so fetch sees the freshly trained value.
    assign lk_cnt = (train && (up_idx == lk_idx)) ? cnt_nxt : bht[lk_idx];

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            bht[init_idx] <= CNT_WNT;
        end else if (train) begin
            bht[up_idx] <= cnt_nxt;
        end
    end

`ifdef BRANCH_BTB_EN
    localparam int TAG_LO = INDEX_BITS + 2;

    logic                btb_vld [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag [ENTRIES];
    logic [XLEN-1:0]     btb_tgt [ENTRIES];
    logic                btb_alw [ENTRIES];

    logic                btb_wr, byp, hit, lk_vld, lk_alw;
    logic [TAG_BITS-1:0] lk_tag, up_tag, lk_stag;
    logic [XLEN-1:0]     lk_tgt;

    assign btb_wr = bp.resolve_valid_in && (state == RUN) && taken;
    assign lk_tag = bp.lookup_pc_in[TAG_BITS+TAG_LO-1:TAG_LO];
    assign up_tag = bp.resolve_pc_in[TAG_BITS+TAG_LO-1:TAG_LO];
    assign byp    = btb_wr && (up_idx == lk_idx);

    assign lk_vld  = byp ? 1'b1                                     : btb_vld[lk_idx];
    assign lk_stag = byp ? up_tag                                   : btb_tag[lk_idx];
    assign lk_tgt  = byp ? bp.resolve_target_in                     : btb_tgt[lk_idx];
    assign lk_alw  = byp ? (bp.resolve_op_in == BRANCH_OP_ALWAYS)   : btb_alw[lk_idx];

    assign hit            = lk_vld && (lk_stag == lk_tag);
    assign pred_taken_nxt = hit && (lk_cnt[COUNTER_BITS-1] || lk_alw);
    assign pred_tgt_nxt   = hit ? lk_tgt : '0;

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            btb_vld[init_idx] <= 1'b0;
        end else if (btb_wr) begin
            btb_vld[up_idx] <= 1'b1;
            btb_tag[up_idx] <= up_tag;
            btb_tgt[up_idx] <= bp.resolve_target_in;
            btb_alw[up_idx] <= (bp.resolve_op_in == BRANCH_OP_ALWAYS);
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.lookup_pc_in[1:0], bp.resolve_pc_in[1:0]};
`else
    localparam int unused_tag_bits = TAG_BITS;

    assign pred_taken_nxt = lk_cnt[COUNTER_BITS-1];
    assign pred_tgt_nxt   = '0;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.lookup_pc_in[1:0], bp.resolve_pc_in[1:0],
                              bp.lookup_pc_in[XLEN-1:INDEX_BITS+2],
                              bp.resolve_pc_in[XLEN-1:INDEX_BITS+2], bp.resolve_target_in};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= INIT;
            init_idx              <= '0;
            bp.ready_out          <= 1'b0;
            bp.predict_valid_out  <= 1'b0;
            bp.predict_taken_out  <= 1'b0;
            bp.predict_target_out <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_idx              <= init_idx + 1'b1;
                    bp.predict_valid_out  <= 1'b0;
                    bp.predict_taken_out  <= 1'b0;
                    bp.predict_target_out <= '0;
                    if (init_idx == LAST_IDX) begin
                        state        <= RUN;
                        bp.ready_out <= 1'b1;
                    end
                end
                default: begin
                    bp.predict_valid_out  <= bp.lookup_valid_in;
                    bp.predict_taken_out  <= bp.lookup_valid_in & pred_taken_nxt;
                    bp.predict_target_out <= bp.lookup_valid_in ? pred_tgt_nxt : '0;
                end
            endcase
        end
    end
endmodule
